rv32im_alu_issue: RTL

Decode/issue stage that drives the integer ALU's input side: operation code, two operands and the data-ready strobe.
- Accepts one instruction word per handshake from fetch and reads the register file by address.
- Decodes OP, OP-IMM, LUI and AUIPC into the ALU 4-bit operation encoding plus operands.
- Holds the result in a single pipeline register with downstream stall and synchronous flush.

---
 rtl/rv32im_alu_issue.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/rv32im_alu_issue.sv
// RV32IM decode/issue stage feeding the integer ALU: decodes OP, OP-IMM, LUI and
// AUIPC into a registered ALU operation and operands. Define RV32IM_ALU_ISSUE_ILLEGAL_TRAP_EN to flag unsupported encodings.
module rv32im_alu_issue #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            clear_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            instr_valid_i,
  output logic            instr_ready_o,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            stall_i,
  output logic [3:0]      operation_o,
  output logic [XLEN-1:0] operand1_o,
  output logic [XLEN-1:0] operand2_o,
  output logic            data_ready_o,
  output logic [4:0]      rd_o,
  output logic            rd_write_o,
  output logic            illegal_o
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_e;

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111
  } opcode_e;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt;

  logic            dec_legal;
  alu_op_e         dec_op;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;

  logic            accept;

  alu_op_e         op_q, op_d;
  logic [XLEN-1:0] opa_q, opa_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic            ready_q, ready_d;
  logic [4:0]      rd_q, rd_d;
  logic            rd_write_q, rd_write_d;
  logic            illegal_q, illegal_d;

  assign opcode     = instr_i[6:0];
  assign funct3     = instr_i[14:12];
  assign funct7     = instr_i[31:25];
  assign rs1_addr_o = instr_i[19:15];
  assign rs2_addr_o = instr_i[24:20];

  // x0 reads as zero whatever the register file returns
  assign rs1_val = (rs1_addr_o == 5'd0) ? '0 : rs1_data_i;
  assign rs2_val = (rs2_addr_o == 5'd0) ? '0 : rs2_data_i;
  assign imm_i   = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
  assign imm_u   = {instr_i[31:12], 12'b0};
  assign shamt   = {{(XLEN-5){1'b0}}, instr_i[24:20]};

  assign instr_ready_o = reset_ni & ~clear_i & (~ready_q | ~stall_i);
  assign accept        = instr_valid_i & instr_ready_o;

  always_comb begin
    dec_legal = 1'b0;
    dec_op    = ALU_ADD;
    dec_a     = '0;
    dec_b     = '0;
    case (opcode)
      OPC_OP: begin
        dec_a  = rs1_val;
        dec_b  = rs2_val;
        dec_op = alu_op_e'({funct7[5], funct3});
        if (funct7 == 7'b0000000) begin
          dec_legal = 1'b1;
        end else if (funct7 == 7'b0100000 &&
                     (funct3 == 3'b000 || funct3 == 3'b101)) begin
          dec_legal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec_a     = rs1_val;
        dec_b     = imm_i;
        dec_op    = alu_op_e'({1'b0, funct3});
        dec_legal = 1'b1;
        if (funct3 == 3'b001) begin
          dec_b     = shamt;
          dec_legal = (funct7 == 7'b0000000);
        end else if (funct3 == 3'b101) begin
          dec_b = shamt;
          if (funct7 == 7'b0000000) begin
            dec_op = ALU_SRL;
          end else if (funct7 == 7'b0100000) begin
            dec_op = ALU_SRA;
          end else begin
            dec_legal = 1'b0;
          end
        end
      end
      OPC_LUI: begin
        dec_b     = imm_u;
        dec_legal = 1'b1;
      end
      OPC_AUIPC: begin
        dec_a     = pc_i;
        dec_b     = imm_u;
        dec_legal = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    op_d       = op_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    ready_d    = ready_q;
    rd_d       = rd_q;
    rd_write_d = rd_write_q;
    illegal_d  = illegal_q;
    if (clear_i) begin
      ready_d    = 1'b0;
      rd_write_d = 1'b0;
      illegal_d  = 1'b0;
    end else if (accept) begin
      rd_d = instr_i[11:7];
      if (dec_legal) begin
        op_d       = dec_op;
        opa_d      = dec_a;
        opb_d      = dec_b;
        ready_d    = 1'b1;
        rd_write_d = (instr_i[11:7] != 5'd0);
        illegal_d  = 1'b0;
      end else begin
`ifdef RV32IM_ALU_ISSUE_ILLEGAL_TRAP_EN
        ready_d    = 1'b0;
        rd_write_d = 1'b0;
        illegal_d  = 1'b1;
`else
        op_d       = ALU_ADD;
        opa_d      = '0;
        opb_d      = '0;
        ready_d    = 1'b1;
        rd_write_d = 1'b0;
        illegal_d  = 1'b0;
`endif
      end
    end else if (!stall_i) begin
      // releasing the stall retires both a valid issue and a pending illegal flag
      ready_d   = 1'b0;
      illegal_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      op_q       <= ALU_ADD;
      opa_q      <= '0;
      opb_q      <= '0;
      ready_q    <= 1'b0;
      rd_q       <= '0;
      rd_write_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      op_q       <= op_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      ready_q    <= ready_d;
      rd_q       <= rd_d;
      rd_write_q <= rd_write_d;
      illegal_q  <= illegal_d;
    end
  end

  assign operation_o  = op_q;
  assign operand1_o   = opa_q;
  assign operand2_o   = opb_q;
  assign data_ready_o = ready_q;
  assign rd_o         = rd_q;
  assign rd_write_o   = rd_write_q;
  assign illegal_o    = illegal_q;

endmodule
